// File: rtl/mc10_vram_arbiter.sv
// mc10_vram_arbiter
//   Shares one synchronous video RAM between the VDG (video display
//   generator) and the CPU. It also holds the VDG mode latch.
//   A free-running 2-bit slot counter splits time into four slots:
//     slot 0 : VDG address on the RAM; the CPU can never issue here.
//     slot 1 : the VDG byte returned by the RAM is captured into vdg_dd.
//     slot 1/2 : the only slots in which a CPU access (ISSUE) may occur.
//   CPU address map: 0x4000-0x5FFF is RAM, 0xBxxx is the mode latch,
//   and every other address is unmapped (reads return 0xFF).
//
// Ports
//   clk, reset         clock; synchronous active-high reset
//   vdg_addr[12:0]     VDG fetch address
//   vdg_dd[7:0]        registered VDG byte; an_s = vdg_dd[7], inv = vdg_dd[6]
//   cpu_addr/din/we    CPU request fields, captured when the request is accepted
//   cpu_req            level request, held until cpu_ack
//   cpu_ack            one-cycle completion pulse; cpu_dout is valid with it
//   ram_addr/we/din    synchronous RAM port (read data one cycle later)
//   ram_dout           RAM read data
//   an_g, gm, css, sound  mode latch outputs
module mc10_vram_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] vdg_addr,
  output logic [7:0]  vdg_dd,
  output logic        an_s,
  output logic        inv,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_req,
  input  logic        cpu_we,
  output logic        cpu_ack,
  output logic [7:0]  cpu_dout,
  output logic [12:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout,
  output logic        an_g,
  output logic [2:0]  gm,
  output logic        css,
  output logic        sound
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  slot_q, slot_d;
  logic [7:0]  vdg_dd_q, vdg_dd_d;
  logic [15:0] req_addr_q, req_addr_d;
  logic [7:0]  req_din_q, req_din_d;
  logic        req_we_q, req_we_d;
  logic        sound_q, sound_d;
  logic        css_q, css_d;
  logic        an_g_q, an_g_d;
  logic [2:0]  gm_q, gm_d;

  logic        in_ram;
  logic        in_mode;
  logic        issue_ram;

  // The request is decoded from the copy captured on acceptance. That way a
  // CPU that drops cpu_req or changes its address during ISSUE cannot
  // disturb an access that is already in flight.
  assign in_ram  = (req_addr_q[15:13] == 3'b010);
  assign in_mode = (req_addr_q[15:12] == 4'hB);

  always_comb begin
    slot_d     = slot_q + 2'd1;
    state_d    = state_q;
    req_addr_d = req_addr_q;
    req_din_d  = req_din_q;
    req_we_d   = req_we_q;
    sound_d    = sound_q;
    css_d      = css_q;
    an_g_d     = an_g_q;
    gm_d       = gm_q;
    // The RAM answers the slot-0 VDG address during slot 1.
    vdg_dd_d   = (slot_q == 2'd1) ? ram_dout : vdg_dd_q;

    case (state_q)
      ST_IDLE: begin
        // Decide one cycle early. ISSUE then lands in slot 1 or 2, never
        // in slot 0, so the VDG fetch slot always stays free.
        if (cpu_req && ((slot_d == 2'd1) || (slot_d == 2'd2))) begin
          state_d    = ST_ISSUE;
          req_addr_d = cpu_addr;
          req_din_d  = cpu_din;
          req_we_d   = cpu_we;
        end
      end
      ST_ISSUE: begin
        state_d = ST_DONE;
        if (in_mode && req_we_q) begin
          sound_d = req_din_q[7];
          css_d   = req_din_q[6];
          an_g_d  = req_din_q[5];
          gm_d    = req_din_q[4:2];
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    req_addr_q <= req_addr_d;
    req_din_q  <= req_din_d;
    req_we_q   <= req_we_d;
    if (reset) begin
      slot_q   <= 2'd0;
      state_q  <= ST_IDLE;
      vdg_dd_q <= 8'h00;
      sound_q  <= 1'b0;
      css_q    <= 1'b0;
      an_g_q   <= 1'b0;
      gm_q     <= 3'b000;
    end else begin
      slot_q   <= slot_d;
      state_q  <= state_d;
      vdg_dd_q <= vdg_dd_d;
      sound_q  <= sound_d;
      css_q    <= css_d;
      an_g_q   <= an_g_d;
      gm_q     <= gm_d;
    end
  end

  // The RAM strobes are gated by reset as well. A write whose ISSUE cycle
  // coincides with reset is therefore dropped, not committed.
  assign issue_ram = (state_q == ST_ISSUE) && in_ram && !reset;

  always_comb begin
    ram_addr = issue_ram ? req_addr_q[12:0] : vdg_addr;
    ram_we   = issue_ram && req_we_q;
    ram_din  = issue_ram ? req_din_q : 8'h00;
  end

  always_comb begin
    cpu_ack  = (state_q == ST_DONE) && !reset;
    cpu_dout = 8'h00;
    if (cpu_ack && !req_we_q) begin
      if (in_ram)
        cpu_dout = ram_dout;
      else if (in_mode)
        cpu_dout = {sound_q, css_q, an_g_q, gm_q, 2'b00};
      else
        cpu_dout = 8'hFF;
    end
  end

  assign vdg_dd = vdg_dd_q;
  assign an_s   = vdg_dd_q[7];
  assign inv    = vdg_dd_q[6];
  assign sound  = sound_q;
  assign css    = css_q;
  assign an_g   = an_g_q;
  assign gm     = gm_q;

endmodule

// File: tb/tb_mc10_vram_arbiter.sv
// Directed testbench for mc10_vram_arbiter with a behavioural synchronous RAM.
module tb_mc10_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] vdg_addr;
  logic [7:0]  vdg_dd;
  logic        an_s, inv;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_req, cpu_we;
  logic        cpu_ack;
  logic [7:0]  cpu_dout;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic        an_g, css, sound;
  logic [2:0]  gm;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] mem [0:8191] = '{default: 8'h00};
  logic       loaded = 1'b0;
  int         wr_cnt = 0;

  mc10_vram_arbiter dut (
    .clk(clk), .reset(reset), .vdg_addr(vdg_addr), .vdg_dd(vdg_dd),
    .an_s(an_s), .inv(inv), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .an_g(an_g), .gm(gm), .css(css), .sound(sound)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model; the first edge preloads the known contents.
  always @(posedge clk) begin
    if (!loaded) begin
      mem[13'h0123] <= 8'hC5;
      mem[13'h0000] <= 8'h11;
      loaded        <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
      wr_cnt        <= wr_cnt + 1;
    end
    ram_dout <= mem[ram_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_slot(input int s);
    step();
    while ((cyc % 4) != s) step();
  endtask

  task automatic do_access(input logic [15:0] a, input logic w, input logic [7:0] d,
                           output logic [7:0] dout, output int lat);
    bit got;
    got      = 1'b0;
    lat      = -1;
    dout     = 8'h00;
    cpu_addr = a;
    cpu_we   = w;
    cpu_din  = d;
    cpu_req  = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      if (!got) begin
        step();
        if (cpu_ack === 1'b1) begin
          got  = 1'b1;
          lat  = i;
          dout = cpu_dout;
        end
      end
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    total++;
    if (vdg_dd !== 8'h00) begin bad++; $display("FAIL reset_vdg_dd got=%h exp=00", vdg_dd); end
    total++;
    if ({an_s, inv, an_g, css, sound, gm} !== 8'h00) begin
      bad++; $display("FAIL reset_flags got=%b exp=00000000", {an_s, inv, an_g, css, sound, gm});
    end
    total++;
    if ({cpu_ack, cpu_dout} !== 9'h000) begin
      bad++; $display("FAIL reset_cpu ack=%b dout=%h exp ack=0 dout=00", cpu_ack, cpu_dout);
    end
    total++;
    if ({ram_we, ram_din} !== 9'h000) begin
      bad++; $display("FAIL reset_ram we=%b din=%h exp we=0 din=00", ram_we, ram_din);
    end
    reset = 1'b0;
    cyc   = 0;
    total++;
    if (ram_addr !== 13'h0123 || ram_we !== 1'b0) begin
      bad++; $display("FAIL first_slot0 addr=%h we=%b exp addr=0123 we=0", ram_addr, ram_we);
    end
  endtask

  task automatic test_vdg_fetch();
    total++;
    if (vdg_dd !== 8'h00) begin bad++; $display("FAIL vdg_cyc0 got=%h exp=00", vdg_dd); end
    step();
    total++;
    if (vdg_dd !== 8'h00) begin bad++; $display("FAIL vdg_cyc1 got=%h exp=00", vdg_dd); end
    step();
    total++;
    if (vdg_dd !== 8'hC5 || {an_s, inv} !== 2'b11) begin
      bad++; $display("FAIL vdg_load got=%h an_s/inv=%b exp=c5 11", vdg_dd, {an_s, inv});
    end
    for (int i = 3; i <= 5; i++) begin
      step();
      total++;
      if (vdg_dd !== 8'hC5) begin bad++; $display("FAIL vdg_hold cyc=%0d got=%h exp=c5", cyc, vdg_dd); end
      if (cyc == 4) vdg_addr = 13'h0000;
    end
    step();
    total++;
    if (vdg_dd !== 8'h11 || {an_s, inv} !== 2'b00) begin
      bad++; $display("FAIL vdg_reload got=%h an_s/inv=%b exp=11 00", vdg_dd, {an_s, inv});
    end
    vdg_addr = 13'h0123;
  endtask

  task automatic test_ram_write();
    logic [7:0] dout;
    int lat;
    wait_slot(0);
    cpu_addr = 16'h4010; cpu_din = 8'h5A; cpu_we = 1'b1; cpu_req = 1'b1;
    step();
    total++;
    if (ram_addr !== 13'h0010 || ram_we !== 1'b1 || ram_din !== 8'h5A || cpu_ack !== 1'b0) begin
      bad++; $display("FAIL wr_issue addr=%h we=%b din=%h ack=%b exp 0010 1 5a 0", ram_addr, ram_we, ram_din, cpu_ack);
    end
    step();
    total++;
    if (cpu_ack !== 1'b1 || (cyc % 4) != 2) begin
      bad++; $display("FAIL wr_ack ack=%b slot=%0d exp ack=1 slot=2", cpu_ack, cyc % 4);
    end
    total++;
    if (ram_we !== 1'b0 || ram_din !== 8'h00) begin
      bad++; $display("FAIL wr_idle_ram we=%b din=%h exp 0 00", ram_we, ram_din);
    end
    cpu_req = 1'b0;
    step();
    total++;
    if (cpu_ack !== 1'b0 || mem[13'h0010] !== 8'h5A) begin
      bad++; $display("FAIL wr_after ack=%b mem=%h exp 0 5a", cpu_ack, mem[13'h0010]);
    end
    do_access(16'h4010, 1'b0, 8'h00, dout, lat);
    total++;
    if (dout !== 8'h5A || lat != 3) begin
      bad++; $display("FAIL rd_4010 dout=%h lat=%0d exp 5a 3", dout, lat);
    end
  endtask

  task automatic test_mode();
    logic [7:0] dout;
    int lat;
    wait_slot(1);
    do_access(16'hBFFF, 1'b1, 8'hE4, dout, lat);
    step();
    total++;
    if ({sound, css, an_g, gm} !== 6'b111001 || lat < 1) begin
      bad++; $display("FAIL mode_wr_e4 got=%b lat=%0d exp=111001", {sound, css, an_g, gm}, lat);
    end
    do_access(16'hB000, 1'b0, 8'h00, dout, lat);
    total++;
    if (dout !== 8'hE4 || lat < 1) begin bad++; $display("FAIL mode_rd_e4 got=%h lat=%0d exp=e4", dout, lat); end
    step();
    do_access(16'hB123, 1'b1, 8'h1C, dout, lat);
    step();
    total++;
    if ({sound, css, an_g, gm} !== 6'b000111) begin
      bad++; $display("FAIL mode_wr_1c got=%b exp=000111", {sound, css, an_g, gm});
    end
    do_access(16'hBABC, 1'b0, 8'h00, dout, lat);
    total++;
    if (dout !== 8'h1C) begin bad++; $display("FAIL mode_rd_1c got=%h exp=1c", dout); end
  endtask

  task automatic test_unmapped();
    logic [7:0] dout;
    int lat;
    int w0;
    wait_slot(3);
    w0 = wr_cnt;
    do_access(16'h8000, 1'b0, 8'h00, dout, lat);
    total++;
    if (dout !== 8'hFF || lat < 1) begin bad++; $display("FAIL unm_rd got=%h lat=%0d exp=ff", dout, lat); end
    step();
    do_access(16'hC000, 1'b1, 8'hAB, dout, lat);
    step();
    total++;
    if (wr_cnt != w0 || lat < 1) begin bad++; $display("FAIL unm_ram_wr writes=%0d exp=%0d", wr_cnt - w0, 0); end
    total++;
    if ({sound, css, an_g, gm} !== 6'b000111 || vdg_dd !== 8'hC5) begin
      bad++; $display("FAIL unm_side mode=%b vdg=%h exp 000111 c5", {sound, css, an_g, gm}, vdg_dd);
    end
  endtask

  task automatic test_latency();
    logic [7:0] dout;
    int lat;
    int exp_lat [4] = '{2, 2, 4, 3};
    for (int s = 0; s < 4; s++) begin
      wait_slot(s);
      do_access(16'h4010, 1'b0, 8'h00, dout, lat);
      total++;
      if (lat != exp_lat[s] || dout !== 8'h5A) begin
        bad++; $display("FAIL lat_slot%0d lat=%0d dout=%h exp %0d 5a", s, lat, dout, exp_lat[s]);
      end
      if (s == 1) begin
        total++;
        if ((cyc % 4) != 3) begin bad++; $display("FAIL done_slot got=%0d exp=3", cyc % 4); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int last;
    int n;
    last = -100;
    n    = 0;
    wait_slot(0);
    cpu_addr = 16'h4010; cpu_we = 1'b0; cpu_din = 8'h00; cpu_req = 1'b1;
    for (int i = 0; i < 64; i++) begin
      step();
      if ((cyc % 4) == 0) begin
        total++;
        if (ram_addr !== 13'h0123 || ram_we !== 1'b0) begin
          bad++; $display("FAIL b2b_slot0 cyc=%0d addr=%h we=%b exp 0123 0", cyc, ram_addr, ram_we);
        end
      end
      if (cpu_ack === 1'b1) begin
        total++;
        if (cpu_dout !== 8'h5A || (n > 0 && (cyc - last) < 3)) begin
          bad++; $display("FAIL b2b_ack cyc=%0d dout=%h gap=%0d exp 5a gap>=3", cyc, cpu_dout, cyc - last);
        end
        last = cyc;
        n++;
      end
    end
    cpu_req = 1'b0;
    total++;
    if (n < 16) begin bad++; $display("FAIL b2b_count got=%0d exp>=16", n); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] dout;
    int lat;
    int w0;
    wait_slot(0);
    w0 = wr_cnt;
    cpu_addr = 16'h4000; cpu_din = 8'h77; cpu_we = 1'b1; cpu_req = 1'b1;
    step();
    total++;
    if (ram_we !== 1'b1 || ram_addr !== 13'h0000) begin
      bad++; $display("FAIL rst_pre_issue we=%b addr=%h exp 1 0000", ram_we, ram_addr);
    end
    reset = 1'b1;
    #1;
    total++;
    if (ram_we !== 1'b0) begin bad++; $display("FAIL rst_we_gate got=%b exp=0", ram_we); end
    step();
    cpu_req = 1'b0;
    total++;
    if (mem[13'h0000] !== 8'h11 || wr_cnt != w0) begin
      bad++; $display("FAIL rst_mem got=%h writes=%0d exp 11 0", mem[13'h0000], wr_cnt - w0);
    end
    total++;
    if ({cpu_ack, cpu_dout, vdg_dd, an_s, inv, an_g, css, sound, gm, ram_we} !== 25'h0) begin
      bad++; $display("FAIL rst_outputs ack=%b dout=%h vdg=%h mode=%b we=%b exp all 0", cpu_ack, cpu_dout, vdg_dd, {an_s, inv, an_g, css, sound, gm}, ram_we);
    end
    step();
    reset = 1'b0;
    cyc   = 0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (cpu_ack !== 1'b0) begin bad++; $display("FAIL rst_no_ack cyc=%0d got=%b exp=0", cyc, cpu_ack); end
      step();
    end
    do_access(16'hB000, 1'b0, 8'h00, dout, lat);
    total++;
    if (dout !== 8'h00 || lat < 1) begin bad++; $display("FAIL rst_mode_rd got=%h lat=%0d exp=00", dout, lat); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    vdg_addr = 13'h0123;
    cpu_addr = 16'h0000;
    cpu_din  = 8'h00;
    cpu_req  = 1'b0;
    cpu_we   = 1'b0;
    test_reset();
    test_vdg_fetch();
    test_ram_write();
    test_mode();
    test_unmapped();
    test_latency();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
